// File: rtl/atm_entry_pkg.sv
// Shared key codes, opcodes and entry-state encoding for the ATM keypad front-end.
package atm_entry_pkg;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_CLEAR  = 4'd11;
  localparam logic [3:0] KEY_CANCEL = 4'd12;

  localparam logic [2:0] OP_BALANCE  = 3'd3;
  localparam logic [2:0] OP_WITHDRAW = 3'd4;
  localparam logic [2:0] OP_DEPOSIT  = 3'd5;
  localparam logic [2:0] OP_CHPIN    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCT   = 3'd1,
    ST_PIN    = 3'd2,
    ST_OP     = 3'd3,
    ST_AMOUNT = 3'd4,
    ST_NEWPIN = 3'd5,
    ST_SEND   = 3'd6
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal field accumulator: value = value*10 + digit, refusing digits past max_digits.
module dec_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        digit_stb,
  input  logic [3:0]  digit,
  input  logic [3:0]  max_digits,
  output logic [31:0] value,
  output logic [3:0]  count,
  output logic        overflow
);

  logic [31:0] value_q, value_d;
  logic [3:0]  count_q, count_d;

  assign overflow = digit_stb && (count_q >= max_digits);

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear) begin
      value_d = '0;
      count_d = '0;
    end else if (digit_stb && !overflow) begin
      value_d = value_q * 32'd10 + {28'd0, digit};
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value = value_q;
  assign count = count_q;

endmodule

// File: rtl/atm_key_entry.sv
// Keypad entry FSM: builds account, PIN, operation, amount and new PIN, then
// holds one transaction on a valid/ready handshake. Includes inactivity timeout.
module atm_key_entry
  import atm_entry_pkg::*;
#(
  parameter int AMT_DIGITS     = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        language_in,
  input  logic        txn_ready,
  output logic        txn_valid,
  output logic [2:0]  txn_operation,
  output logic [3:0]  txn_acc_num,
  output logic [15:0] txn_pin,
  output logic [15:0] txn_new_pin,
  output logic [31:0] txn_amount,
  output logic        txn_language,
  output logic [2:0]  entry_state,
  output logic [3:0]  digit_count,
  output logic        key_error,
  output logic        timeout
);

  entry_state_t state_q, state_d;
  logic [3:0]   acc_num_q, acc_num_d;
  logic [15:0]  pin_q, pin_d, new_pin_q, new_pin_d;
  logic [31:0]  amount_q, amount_d;
  logic [2:0]   op_q, op_d;
  logic         lang_q, lang_d, valid_q, valid_d;
  logic         key_error_q, key_error_d, timeout_q, timeout_d;
  logic [31:0]  idle_cnt_q, idle_cnt_d;

  logic         acc_clear, acc_stb, acc_ovf, abort;
  logic [3:0]   acc_max, acc_count;
  logic [31:0]  acc_value;

  dec_accumulator u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .digit_stb  (acc_stb),
    .digit      (key_code),
    .max_digits (acc_max),
    .value      (acc_value),
    .count      (acc_count),
    .overflow   (acc_ovf)
  );

  always_comb begin
    case (state_q)
      ST_IDLE, ST_ACCT:    acc_max = 4'd2;
      ST_PIN, ST_NEWPIN:   acc_max = 4'd4;
      ST_AMOUNT:           acc_max = 4'(AMT_DIGITS);
      default:             acc_max = 4'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_num_d   = acc_num_q;
    pin_d       = pin_q;
    new_pin_d   = new_pin_q;
    amount_d    = amount_q;
    op_d        = op_q;
    lang_d      = lang_q;
    key_error_d = 1'b0;
    timeout_d   = 1'b0;
    acc_clear   = 1'b0;
    acc_stb     = 1'b0;
    abort       = 1'b0;
    idle_cnt_d  = idle_cnt_q + 32'd1;

    if (key_valid && state_q != ST_SEND) begin
      if (key_code > KEY_CANCEL) begin
        key_error_d = 1'b1;
      end else if (key_code == KEY_CANCEL) begin
        abort = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (is_digit(key_code)) begin
              acc_stb = 1'b1;
              lang_d  = language_in;
              state_d = ST_ACCT;
            end
          end
          ST_OP: begin
            case (key_code)
              4'd3: begin
                op_d    = OP_BALANCE;
                state_d = ST_SEND;
              end
              4'd4, 4'd5: begin
                op_d    = key_code[2:0];
                state_d = ST_AMOUNT;
              end
              4'd6: begin
                op_d    = OP_CHPIN;
                state_d = ST_NEWPIN;
              end
              default: key_error_d = 1'b1;
            endcase
          end
          default: begin
            // Field states: digits go to the accumulator, ENTER commits it.
            if (is_digit(key_code)) begin
              acc_stb     = 1'b1;
              key_error_d = acc_ovf;
            end else if (key_code == KEY_CLEAR) begin
              acc_clear = 1'b1;
            end else begin
              key_error_d = 1'b1;
              case (state_q)
                ST_ACCT: if (acc_value != 32'd0 && acc_value <= 32'd15) begin
                  acc_num_d   = acc_value[3:0];
                  state_d     = ST_PIN;
                  key_error_d = 1'b0;
                end
                ST_PIN: if (acc_count == 4'd4) begin
                  pin_d       = acc_value[15:0];
                  state_d     = ST_OP;
                  key_error_d = 1'b0;
                end
                ST_AMOUNT: if (acc_value != 32'd0) begin
                  amount_d    = acc_value;
                  state_d     = ST_SEND;
                  key_error_d = 1'b0;
                end
                ST_NEWPIN: if (acc_count == 4'd4) begin
                  new_pin_d   = acc_value[15:0];
                  state_d     = ST_SEND;
                  key_error_d = 1'b0;
                end
                default: ;
              endcase
              acc_clear = !key_error_d;
            end
          end
        endcase
      end
    end

    if (state_q == ST_SEND && txn_ready) abort = 1'b1;

    // A key in the expiry cycle takes precedence over the timeout.
    if (key_valid || state_q == ST_IDLE || state_q == ST_SEND) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt_d = '0;
      timeout_d  = 1'b1;
      abort      = 1'b1;
    end

    if (abort) begin
      state_d   = ST_IDLE;
      acc_num_d = '0;
      pin_d     = '0;
      new_pin_d = '0;
      amount_d  = '0;
      op_d      = '0;
      lang_d    = 1'b0;
      acc_clear = 1'b1;
      acc_stb   = 1'b0;
    end

    valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_num_q   <= '0;
      pin_q       <= '0;
      new_pin_q   <= '0;
      amount_q    <= '0;
      op_q        <= '0;
      lang_q      <= 1'b0;
      valid_q     <= 1'b0;
      key_error_q <= 1'b0;
      timeout_q   <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_num_q   <= acc_num_d;
      pin_q       <= pin_d;
      new_pin_q   <= new_pin_d;
      amount_q    <= amount_d;
      op_q        <= op_d;
      lang_q      <= lang_d;
      valid_q     <= valid_d;
      key_error_q <= key_error_d;
      timeout_q   <= timeout_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign txn_valid     = valid_q;
  assign txn_operation = op_q;
  assign txn_acc_num   = acc_num_q;
  assign txn_pin       = pin_q;
  assign txn_new_pin   = new_pin_q;
  assign txn_amount    = amount_q;
  assign txn_language  = lang_q;
  assign entry_state   = state_q;
  assign digit_count   = acc_count;
  assign key_error     = key_error_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_atm_key_entry.sv
// Self-checking bench for atm_key_entry: fixed vector table, directed corner
// sequences and randomized keys against a digit-list reference model.
module tb_atm_key_entry;
  import atm_entry_pkg::*;

  localparam int TMO = 20;
  localparam int AMT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        language_in = 1'b0;
  logic        txn_ready = 1'b0;
  logic        txn_valid;
  logic [2:0]  txn_operation;
  logic [3:0]  txn_acc_num;
  logic [15:0] txn_pin;
  logic [15:0] txn_new_pin;
  logic [31:0] txn_amount;
  logic        txn_language;
  logic [2:0]  entry_state;
  logic [3:0]  digit_count;
  logic        key_error;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  atm_key_entry #(.AMT_DIGITS(AMT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .language_in(language_in), .txn_ready(txn_ready), .txn_valid(txn_valid),
    .txn_operation(txn_operation), .txn_acc_num(txn_acc_num), .txn_pin(txn_pin),
    .txn_new_pin(txn_new_pin), .txn_amount(txn_amount), .txn_language(txn_language),
    .entry_state(entry_state), .digit_count(digit_count), .key_error(key_error),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: the current field is a list of typed digits; its value is
  // only computed (by arithmetic) when ENTER commits it.
  entry_state_t m_st = ST_IDLE;
  int  m_dig[$];
  int  m_acc = 0, m_pin = 0, m_newpin = 0, m_op = 0, m_amt = 0, m_quiet = 0;
  bit  m_lang = 0, m_err = 0, m_tmo = 0;

  function automatic int field_value();
    int v = 0;
    foreach (m_dig[i]) v = v * 10 + m_dig[i];
    return v;
  endfunction

  function automatic int limit_of(entry_state_t s);
    case (s)
      ST_ACCT:           return 2;
      ST_PIN, ST_NEWPIN: return 4;
      ST_AMOUNT:         return AMT;
      default:           return 0;
    endcase
  endfunction

  task automatic model_clear();
    m_st = ST_IDLE; m_dig.delete();
    m_acc = 0; m_pin = 0; m_newpin = 0; m_op = 0; m_amt = 0; m_lang = 0;
  endtask

  task automatic model_step(bit kv, int kc, bit lang, bit rdy, bit rst_i);
    entry_state_t pre;
    bit abort;
    int v, n;
    pre = m_st; abort = 0; m_err = 0; m_tmo = 0;
    if (rst_i) begin
      model_clear();
      m_quiet = 0;
      return;
    end
    if (kv && pre != ST_SEND) begin
      if (kc >= 13) m_err = 1;
      else if (kc == 12) abort = 1;
      else if (pre == ST_IDLE) begin
        if (kc <= 9) begin
          m_dig.push_back(kc); m_lang = lang; m_st = ST_ACCT;
        end
      end else if (pre == ST_OP) begin
        if (kc == 3) begin m_op = 3; m_st = ST_SEND; end
        else if (kc == 4 || kc == 5) begin m_op = kc; m_st = ST_AMOUNT; end
        else if (kc == 6) begin m_op = 6; m_st = ST_NEWPIN; end
        else m_err = 1;
      end else if (kc <= 9) begin
        if (m_dig.size() >= limit_of(pre)) m_err = 1;
        else m_dig.push_back(kc);
      end else if (kc == 11) begin
        m_dig.delete();
      end else begin
        v = field_value(); n = m_dig.size();
        if (pre == ST_ACCT && v >= 1 && v <= 15) begin
          m_acc = v; m_dig.delete(); m_st = ST_PIN;
        end else if (pre == ST_PIN && n == 4) begin
          m_pin = v; m_dig.delete(); m_st = ST_OP;
        end else if (pre == ST_AMOUNT && n >= 1 && v != 0) begin
          m_amt = v; m_dig.delete(); m_st = ST_SEND;
        end else if (pre == ST_NEWPIN && n == 4) begin
          m_newpin = v; m_dig.delete(); m_st = ST_SEND;
        end else m_err = 1;
      end
    end
    if (pre == ST_SEND && rdy) abort = 1;
    if (kv || pre == ST_IDLE || pre == ST_SEND) m_quiet = 0;
    else if (m_quiet == TMO - 1) begin m_quiet = 0; m_tmo = 1; abort = 1; end
    else m_quiet++;
    if (abort) model_clear();
  endtask

  task automatic check(string nm, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("state", entry_state, m_st);
    check("valid", txn_valid, m_st == ST_SEND);
    check("op", txn_operation, m_op);
    check("acc_num", txn_acc_num, m_acc);
    check("pin", txn_pin, m_pin);
    check("new_pin", txn_new_pin, m_newpin);
    check("amount", txn_amount, m_amt);
    check("language", txn_language, m_lang);
    check("digit_count", digit_count, m_dig.size());
    check("key_error", key_error, m_err);
    check("timeout", timeout, m_tmo);
  endtask

  task automatic applyStimulus(bit kv, int kc, bit lang, bit rdy);
    key_valid = kv; key_code = 4'(kc); language_in = lang; txn_ready = rdy;
    @(posedge clk);
    model_step(key_valid, int'(key_code), language_in, txn_ready, rst);
    #1;
    checkOutput();
  endtask

  task automatic press(int kc, bit rdy);
    applyStimulus(1, kc, 0, rdy);
  endtask

  task automatic idle(bit rdy);
    applyStimulus(0, 0, 0, rdy);
  endtask

  typedef struct {
    bit kv; int kc; bit rdy;
    int st; bit err; bit vld; int dc; int op; int acc; int pin; int amt;
  } vec_t;
  vec_t vecs[$];

  task automatic addRow(bit kv, int kc, bit rdy, entry_state_t st, bit err, bit vld,
                        int dc, int op, int acc, int pin, int amt);
    vecs.push_back('{kv, kc, rdy, int'(st), err, vld, dc, op, acc, pin, amt});
  endtask

  initial begin
    addRow(1, 1,  0, ST_ACCT, 0, 0, 1, 0, 0, 0, 0);
    addRow(1, 6,  0, ST_ACCT, 0, 0, 2, 0, 0, 0, 0);
    addRow(1, 10, 0, ST_ACCT, 1, 0, 2, 0, 0, 0, 0);
    addRow(1, 7,  0, ST_ACCT, 1, 0, 2, 0, 0, 0, 0);
    addRow(1, 11, 0, ST_ACCT, 0, 0, 0, 0, 0, 0, 0);
    addRow(1, 10, 0, ST_ACCT, 1, 0, 0, 0, 0, 0, 0);
    addRow(1, 1,  0, ST_ACCT, 0, 0, 1, 0, 0, 0, 0);
    addRow(1, 10, 0, ST_PIN,  0, 0, 0, 0, 1, 0, 0);
    addRow(1, 1,  0, ST_PIN,  0, 0, 1, 0, 1, 0, 0);
    addRow(1, 2,  0, ST_PIN,  0, 0, 2, 0, 1, 0, 0);
    addRow(1, 3,  0, ST_PIN,  0, 0, 3, 0, 1, 0, 0);
    addRow(1, 10, 0, ST_PIN,  1, 0, 3, 0, 1, 0, 0);
    addRow(1, 4,  0, ST_PIN,  0, 0, 4, 0, 1, 0, 0);
    addRow(1, 5,  0, ST_PIN,  1, 0, 4, 0, 1, 0, 0);
    addRow(1, 10, 0, ST_OP,   0, 0, 0, 0, 1, 1234, 0);
    addRow(1, 7,  0, ST_OP,   1, 0, 0, 0, 1, 1234, 0);
    addRow(1, 14, 0, ST_OP,   1, 0, 0, 0, 1, 1234, 0);
    addRow(1, 3,  1, ST_SEND, 0, 1, 0, 3, 1, 1234, 0);
    addRow(0, 0,  1, ST_IDLE, 0, 0, 0, 0, 0, 0, 0);

    rst = 1;
    idle(0);
    check("reset_valid", txn_valid, 0);
    check("reset_state", entry_state, ST_IDLE);
    rst = 0;
    idle(0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].kv, vecs[i].kc, 1, vecs[i].rdy);
      check($sformatf("row%0d_state", i), entry_state, vecs[i].st);
      check($sformatf("row%0d_err", i), key_error, vecs[i].err);
      check($sformatf("row%0d_valid", i), txn_valid, vecs[i].vld);
      check($sformatf("row%0d_dc", i), digit_count, vecs[i].dc);
      check($sformatf("row%0d_op", i), txn_operation, vecs[i].op);
      check($sformatf("row%0d_acc", i), txn_acc_num, vecs[i].acc);
      check($sformatf("row%0d_pin", i), txn_pin, vecs[i].pin);
      check($sformatf("row%0d_amt", i), txn_amount, vecs[i].amt);
    end

    // Withdraw held under backpressure, a key during SEND is ignored.
    idle(0);
    press(2, 0); press(10, 0);
    press(2, 0); press(3, 0); press(4, 0); press(5, 0); press(10, 0);
    press(4, 0); press(5, 0); press(0, 0); press(0, 0); press(10, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) press(7, 0); else idle(0);
      check("wd_valid", txn_valid, 1);
      check("wd_amount", txn_amount, 500);
      check("wd_op", txn_operation, 4);
      check("wd_err", key_error, 0);
    end
    idle(1);
    check("wd_accept_state", entry_state, ST_IDLE);
    check("wd_accept_amount", txn_amount, 0);
    idle(0);

    // Change PIN.
    press(1, 0); press(0, 0); press(10, 0);
    press(7, 0); press(1, 0); press(2, 0); press(3, 0); press(10, 0);
    press(6, 0);
    press(4, 0); press(5, 0); press(6, 0); press(7, 0); press(10, 0);
    check("chpin_op", txn_operation, 6);
    check("chpin_new", txn_new_pin, 4567);
    check("chpin_acc", txn_acc_num, 10);
    check("chpin_amount", txn_amount, 0);
    idle(1);
    idle(0);

    // Inactivity timeout after two PIN digits.
    press(3, 0); press(10, 0); press(1, 0); press(2, 0);
    for (int k = 1; k <= 19; k++) begin
      idle(0);
      check("tmo_early", timeout, 0);
    end
    idle(0);
    check("tmo_pulse", timeout, 1);
    check("tmo_state", entry_state, ST_IDLE);
    check("tmo_acc", txn_acc_num, 0);
    idle(0);
    check("tmo_one_cycle", timeout, 0);

    // A key in the expiry cycle wins over the timeout.
    press(3, 0); press(10, 0); press(1, 0);
    for (int k = 1; k <= 19; k++) idle(0);
    press(2, 0);
    check("expiry_key_tmo", timeout, 0);
    check("expiry_key_state", entry_state, ST_PIN);
    check("expiry_key_dc", digit_count, 2);
    press(12, 0);

    // Reset while a transaction is pending.
    press(1, 0); press(10, 0);
    press(1, 0); press(2, 0); press(3, 0); press(4, 0); press(10, 0); press(3, 0);
    check("pre_reset_valid", txn_valid, 1);
    rst = 1;
    idle(0);
    rst = 0;
    check("reset_send_valid", txn_valid, 0);
    check("reset_send_state", entry_state, ST_IDLE);

    // CLEAR mid-amount then re-entry.
    press(4, 0); press(10, 0);
    press(1, 0); press(1, 0); press(1, 0); press(1, 0); press(10, 0);
    press(5, 0); press(1, 0); press(2, 0); press(11, 0);
    check("clr_dc", digit_count, 0);
    press(9, 0); press(9, 0); press(10, 0);
    check("clr_amount", txn_amount, 99);
    check("clr_op", txn_operation, 5);
    idle(1);

    // Randomized traffic with quiet stretches to exercise the timeout.
    for (int seg = 0; seg < 40; seg++) begin
      int dens;
      dens = (seg % 4 == 3) ? 3 : 60;
      for (int t = 0; t < 100; t++) begin
        int r, kc;
        bit kv;
        kv = ($urandom_range(0, 99) < dens);
        r = $urandom_range(0, 99);
        if (r < 70) kc = $urandom_range(0, 9);
        else if (r < 85) kc = 10;
        else if (r < 90) kc = 11;
        else if (r < 93) kc = 12;
        else kc = $urandom_range(13, 15);
        rst = ($urandom_range(0, 999) < 3);
        applyStimulus(kv, kc, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 35));
      end
    end
    rst = 0;
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
